instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stop_IF  input  1  hazard stall; hold ID outputs and stop advancing PC.
REQ-005 set_invalid_IF  input  1  squash; instruction presented to ID next cycle is invalid.
REQ-006 redirect  input  1  taken branch / exception / ret; overrides all other inputs.
REQ-007 redirect_pc  input  32  new fetch address; bits [1:0] ignored, treated as 00.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0.
REQ-010 imem_ready  input  1  response valid this cycle; imem_rdata and imem_fault sampled with it.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 imem_fault  input  1  access fault for current fetch.
REQ-013 ID_instr  output  32  instruction to decode.
REQ-014 ID_PC  output  32  address of ID_instr.
REQ-015 ID_valid  output  1  ID_instr is a real instruction.
REQ-016 fetch_fault  output  1  ID_instr came from a faulting fetch.

Function
REQ-017 FSM states: FETCH, STALL (one-entry hold buffer full), DROP (discard outstanding response).
REQ-018 FETCH: imem_req=1, imem_addr=pc; STALL: imem_req=0; DROP: imem_req=1, imem_addr=stale address.
REQ-019 FETCH, imem_ready=1, stop_IF=0, redirect=0: next edge ID_instr<=imem_rdata, ID_PC<=pc, fetch_fault<=imem_fault, ID_valid<=~set_invalid_IF, pc<=pc+4; latency 1 cycle ready-to-ID.
REQ-020 FETCH, imem_ready=0, no redirect: pc, ID_instr, ID_PC, fetch_fault held; ID_valid<=ID_valid & ~set_invalid_IF when stop_IF=1, else 0 (bubble).
REQ-021 FETCH, imem_ready=1, stop_IF=1, redirect=0: word, pc, fault captured in hold buffer, pc<=pc+4, ID outputs unchanged, -> STALL.
REQ-022 STALL, stop_IF=1: all outputs held; STALL, stop_IF=0: buffer moved to ID outputs (ID_valid<=~set_invalid_IF), buffer emptied, -> FETCH.
REQ-023 redirect=1 (any state): pc<={redirect_pc[31:2],2'b00}, hold buffer cleared, ID_valid<=0; -> DROP if in FETCH or DROP with imem_ready=0, else -> FETCH.
REQ-024 DROP: response discarded on imem_ready=1, then -> FETCH with redirected pc; stop_IF and set_invalid_IF have no effect on pc in DROP; ID_valid stays 0.
REQ-025 set_invalid_IF has no effect on pc or FSM state; only clears ID_valid for the next cycle.
REQ-026 pc arithmetic modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 Faulting fetch advances pc like a normal fetch; fetch_fault=1 with ID_valid=1 delivered to ID.
REQ-028 Simultaneous redirect and stop_IF: redirect wins; simultaneous redirect and imem_ready in FETCH: data discarded, no DROP.

Reset
REQ-029 reset=1 at an edge: state<=FETCH, pc<=RESET_PC, hold buffer empty, ID_valid<=0, ID_instr<=32'h0000_0013, ID_PC<=0, fetch_fault<=0; overrides all other inputs.
REQ-030 imem_req=0 while reset=1; first request at RESET_PC in cycle after reset deasserts.
REQ-031 Reset mid-request: outstanding response ignored; memory must not complete a transaction after the next request begins.

Verification
REQ-032 Reset, imem_ready=1 every cycle, rdata=addr -> ID_PC 0,4,8,... one per cycle, ID_valid=1 from cycle 2.
REQ-033 stop_IF=1 for 3 cycles while ready=1 at pc=8 -> ID holds PC 4, word for 8 buffered, imem_req=0; release -> ID_PC 8, then 12, no loss or duplicate.
REQ-034 redirect to 32'h100 with ready=0 for 2 cycles -> DROP, imem_addr stale until ready, stale word never valid, next fetch addr 32'h100.
REQ-035 redirect_pc=32'h203 -> fetch at 32'h200; pc=32'hFFFF_FFFC fetch -> next addr 0.
REQ-036 set_invalid_IF one cycle during stream -> exactly one ID_valid=0 slot, pc sequence unaffected; imem_fault=1 -> fetch_fault=1 on that PC only.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: one request at a time to instruction memory, a
// one-entry hold buffer for stalls, and a drop state to discard stale responses.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop_IF,
    input  logic        set_invalid_IF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_fault,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_PC,
    output logic        ID_valid,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {FETCH, STALL, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] stale_addr;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        hold_fault;

    // Request is gated by reset so nothing is issued while reset is held.
    assign imem_req  = !reset && (state != STALL);
    assign imem_addr = (state == DROP) ? stale_addr : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            stale_addr  <= RESET_PC;
            hold_instr  <= 32'h0;
            hold_pc     <= 32'h0;
            hold_fault  <= 1'b0;
            ID_valid    <= 1'b0;
            ID_instr    <= 32'h0000_0013;
            ID_PC       <= 32'h0;
            fetch_fault <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc & 32'hFFFF_FFFC;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
            hold_fault <= 1'b0;
            ID_valid   <= 1'b0;
            // An unanswered request must still be drained at its original address.
            if (state != STALL && !imem_ready) begin
                state <= DROP;
                if (state == FETCH)
                    stale_addr <= pc;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc <= pc + 32'd4;
                        if (stop_IF) begin
                            hold_instr <= imem_rdata;
                            hold_pc    <= pc;
                            hold_fault <= imem_fault;
                            ID_valid   <= ID_valid & ~set_invalid_IF;
                            state      <= STALL;
                        end else begin
                            ID_instr    <= imem_rdata;
                            ID_PC       <= pc;
                            fetch_fault <= imem_fault;
                            ID_valid    <= ~set_invalid_IF;
                        end
                    end else begin
                        ID_valid <= stop_IF ? (ID_valid & ~set_invalid_IF) : 1'b0;
                    end
                end
                STALL: begin
                    if (!stop_IF) begin
                        ID_instr    <= hold_instr;
                        ID_PC       <= hold_pc;
                        fetch_fault <= hold_fault;
                        ID_valid    <= ~set_invalid_IF;
                        hold_instr  <= 32'h0;
                        hold_pc     <= 32'h0;
                        hold_fault  <= 1'b0;
                        state       <= FETCH;
                    end else begin
                        ID_valid <= ID_valid & ~set_invalid_IF;
                    end
                end
                DROP: begin
                    ID_valid <= 1'b0;
                    if (imem_ready)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic,
// all cycles checked against a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop_IF = 1'b0;
    logic        set_invalid_IF = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_fault = 1'b0;
    logic [31:0] ID_instr;
    logic [31:0] ID_PC;
    logic        ID_valid;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stop_IF(stop_IF), .set_invalid_IF(set_invalid_IF),
        .redirect(redirect), .redirect_pc(redirect_pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_fault(imem_fault), .ID_instr(ID_instr), .ID_PC(ID_PC),
        .ID_valid(ID_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Reference model: pc, a queue for captured-but-undelivered words, and a
    // flag saying an abandoned request is still outstanding at m_stale.
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic fault; } entry_t;
    entry_t      m_buf[$];
    logic [31:0] m_pc, m_stale, m_instr, m_idpc;
    logic        m_drop, m_idv, m_ff;

    function automatic logic exp_req(input logic rst);
        return !rst && (m_buf.size() == 0);
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_drop ? m_stale : m_pc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_pc = RESET_PC; m_stale = RESET_PC; m_drop = 1'b0;
        m_idv = 1'b0; m_instr = 32'h0000_0013; m_idpc = 32'h0; m_ff = 1'b0;
    endtask

    // One clock: drive inputs, check DUT against model mid-cycle, advance model.
    task automatic step(input logic rst, input logic stop, input logic inv,
                        input logic redir, input logic [31:0] rpc,
                        input logic rdy, input logic flt);
        logic   req, rdy_e, nd;
        entry_t e;
        req            = exp_req(rst);
        rdy_e          = rdy && req;
        reset          = rst;
        stop_IF        = stop;
        set_invalid_IF = inv;
        redirect       = redir;
        redirect_pc    = rpc;
        imem_ready     = rdy_e;
        imem_rdata     = exp_addr();
        imem_fault     = flt && rdy_e;
        #4;
        chk("imem_req", {31'b0, imem_req}, {31'b0, req});
        if (req) chk("imem_addr", imem_addr, exp_addr());
        chk("ID_valid", {31'b0, ID_valid}, {31'b0, m_idv});
        chk("ID_PC", ID_PC, m_idpc);
        chk("ID_instr", ID_instr, m_instr);
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_ff});
        if (rst) begin
            model_reset();
        end else if (redir) begin
            nd = req && !rdy_e;
            if (nd && !m_drop) m_stale = m_pc;
            m_drop = nd;
            m_pc   = rpc & 32'hFFFF_FFFC;
            m_buf.delete();
            m_idv  = 1'b0;
        end else if (m_drop) begin
            m_idv = 1'b0;
            if (rdy_e) m_drop = 1'b0;
        end else if (m_buf.size() != 0) begin
            if (!stop) begin
                e = m_buf.pop_front();
                m_instr = e.instr; m_idpc = e.pc; m_ff = e.fault; m_idv = !inv;
            end else begin
                m_idv = m_idv && !inv;
            end
        end else if (rdy_e) begin
            if (stop) begin
                e.instr = imem_rdata; e.pc = m_pc; e.fault = imem_fault;
                m_buf.push_back(e);
                m_idv = m_idv && !inv;
            end else begin
                m_instr = imem_rdata; m_idpc = m_pc; m_ff = imem_fault; m_idv = !inv;
            end
            m_pc = m_pc + 32'd4;
        end else begin
            m_idv = stop ? (m_idv && !inv) : 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic s, v, r;
        @(posedge clk);
        #1;
        model_reset();
        step(1, 0, 0, 0, 0, 1, 0);
        chk("rst_ID_valid", {31'b0, ID_valid}, 32'h0);
        chk("rst_ID_instr", ID_instr, 32'h0000_0013);
        chk("rst_ID_PC", ID_PC, 32'h0);

        // Streaming with memory always ready: one word per cycle.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("stream_ID_PC", ID_PC, 32'h4);
        chk("stream_valid", {31'b0, ID_valid}, 32'h1);

        // Stall for three cycles while pc=8 is answered.
        repeat (3) step(0, 1, 0, 0, 0, 1, 0);
        chk("stall_ID_PC", ID_PC, 32'h4);
        chk("stall_req", {31'b0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("release_ID_PC", ID_PC, 32'h8);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("after_release_PC", ID_PC, 32'hC);

        // Redirect while the fetch at 0x10 is still pending.
        step(0, 0, 0, 1, 32'h100, 0, 0);
        chk("drop_stale_addr", imem_addr, 32'h10);
        chk("drop_valid", {31'b0, ID_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("redirect_addr", imem_addr, 32'h100);
        chk("drop_no_valid", {31'b0, ID_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("redirect_ID_PC", ID_PC, 32'h100);

        // Misaligned redirect target and pc wrap.
        step(0, 0, 0, 1, 32'h203, 1, 0);
        chk("align_addr", imem_addr, 32'h200);
        step(0, 1, 0, 1, 32'hFFFF_FFFC, 1, 0);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("wrap_addr1", imem_addr, 32'h0);
        chk("wrap_ID_PC", ID_PC, 32'hFFFF_FFFC);

        // Squash one slot, then one faulting fetch.
        step(0, 0, 1, 0, 0, 1, 0);
        chk("squash_valid", {31'b0, ID_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("fault_set", {31'b0, fetch_fault}, 32'h1);
        chk("fault_valid", {31'b0, ID_valid}, 32'h1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("fault_clear", {31'b0, fetch_fault}, 32'h0);

        // Reset while a request is outstanding.
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_addr", imem_addr, RESET_PC);

        repeat (4000) begin
            s = ($urandom_range(3) == 0);
            v = !s && ($urandom_range(7) == 0);
            r = ($urandom_range(15) == 0);
            step($urandom_range(199) == 0, s, v, r,
                 ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom,
                 $urandom_range(1) == 1, $urandom_range(15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
